// File: rtl/tqv_peri_initiator.sv
// tqv_peri_initiator: requester end of the TinyQV peripheral data bus.
// Takes one read/write command at a time on a valid/ready port, runs a single
// 8/16/32-bit bus transaction and returns status plus read data on a
// valid/ready response port. All bus-facing outputs are registered.
// Optional feature macro: TQV_INIT_TIMEOUT_EN (read wait limit of
// TIMEOUT_CYCLES, after which the read is closed and reported as an error).
module tqv_peri_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [10:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [10:0] addr_out,
  output logic [31:0] data_out,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_in,
  input  logic        data_ready,
  output logic        data_read_complete
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_COMPLETE, S_RESP
  } state_t;

  localparam logic [1:0] SZ_IDLE = 2'b11;

  // The 8-bit wait counter cannot represent a limit outside 1..255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [10:0] addr_d;
  logic [31:0] data_d;
  logic [1:0]  write_n_d, read_n_d;
  logic        complete_d;
  logic        rsp_valid_d;
  logic [31:0] rdata_d;
  logic        err_d;
  logic [31:0] rd_masked;

`ifdef TQV_INIT_TIMEOUT_EN
  logic [7:0]  wait_q, wait_d;
`endif

  assign cmd_ready = (state_q == S_IDLE);

  // Zero-extend the returned word to the size of the access in flight.
  always_comb begin
    case (size_q)
      2'b00:   rd_masked = {24'd0, data_in[7:0]};
      2'b01:   rd_masked = {16'd0, data_in[15:0]};
      default: rd_masked = data_in;
    endcase
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    addr_d      = addr_out;
    data_d      = data_out;
    write_n_d   = SZ_IDLE;           // write strobe lasts exactly one cycle
    read_n_d    = data_read_n;
    complete_d  = 1'b0;              // complete is a single-cycle pulse
    rsp_valid_d = rsp_valid;
    rdata_d     = rsp_rdata;
    err_d       = rsp_err;
`ifdef TQV_INIT_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          size_d = cmd_size;
          addr_d = cmd_addr;
          data_d = cmd_wdata;
          if (cmd_size == SZ_IDLE) begin
            // Illegal size: answer straight away, bus stays idle.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = 32'd0;
            err_d       = 1'b1;
          end else if (cmd_write) begin
            state_d   = S_WRITE;
            write_n_d = cmd_size;
          end else begin
            state_d  = S_READ;
            read_n_d = cmd_size;
`ifdef TQV_INIT_TIMEOUT_EN
            wait_d   = 8'd0;
`endif
          end
        end
      end
      S_WRITE: begin
        // The peripheral acks writes in the strobe cycle.
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rdata_d     = 32'd0;
        err_d       = 1'b0;
      end
      S_READ: begin
        if (data_ready) begin
          state_d    = S_COMPLETE;
          read_n_d   = SZ_IDLE;
          complete_d = 1'b1;
          rdata_d    = rd_masked;
          err_d      = 1'b0;
        end
`ifdef TQV_INIT_TIMEOUT_EN
        else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == 8'(TIMEOUT_CYCLES)) begin
            // Still pulse complete so a responder holding state lets go.
            state_d    = S_COMPLETE;
            read_n_d   = SZ_IDLE;
            complete_d = 1'b1;
            rdata_d    = 32'd0;
            err_d      = 1'b1;
          end
        end
`endif
      end
      S_COMPLETE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        read_n_d    = SZ_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      size_q             <= SZ_IDLE;
      addr_out           <= 11'd0;
      data_out           <= 32'd0;
      data_write_n       <= SZ_IDLE;
      data_read_n        <= SZ_IDLE;
      data_read_complete <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= 32'd0;
      rsp_err            <= 1'b0;
    end else begin
      state_q            <= state_d;
      size_q             <= size_d;
      addr_out           <= addr_d;
      data_out           <= data_d;
      data_write_n       <= write_n_d;
      data_read_n        <= read_n_d;
      data_read_complete <= complete_d;
      rsp_valid          <= rsp_valid_d;
      rsp_rdata          <= rdata_d;
      rsp_err            <= err_d;
    end
  end

`ifdef TQV_INIT_TIMEOUT_EN
  // Cycles spent in READ without data_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= 8'd0;
    else        wait_q <= wait_d;
  end
`endif

endmodule
